// File: rtl/ram_dump_ctrl_pkg.sv
// Shared types and default dump window for the RAM dump controller.
// The defaults cover byte addresses 0..104 in 4-byte words (27 words).
package ram_dump_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } dumpState_e;

    localparam int unsigned DEF_START_ADDR = 0;
    localparam int unsigned DEF_END_ADDR   = 104;
    localparam int unsigned DEF_STEP       = 4;
    localparam int unsigned FIFO_DEPTH     = 2;

endpackage

// File: rtl/ram_dump_ctrl_fifo.sv
// Two-entry output buffer holding {address, data} beats for the dump stream.
// Reset flushes the pointers and count; entry contents are left as they are.
module dump_fifo
    import ram_dump_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wrData,
    output logic [WIDTH-1:0] rdData,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic             wrPtr;
    logic             rdPtr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= 1'b0;
            rdPtr <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) wrPtr <= ~wrPtr;
            if (pop)  rdPtr <= ~rdPtr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= wrData;
    end

    assign rdData = mem[rdPtr];
    assign full   = (count == 2'd2);
    assign empty  = (count == 2'd0);

endmodule

// File: rtl/ram_dump_ctrl.sv
// Walks a fixed byte-address window of a synchronous-read RAM and streams each
// word with its address through a valid/ready interface, one beat per cycle.
module ram_dump_ctrl
    import ram_dump_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned START_ADDR = DEF_START_ADDR,
    parameter int unsigned END_ADDR   = DEF_END_ADDR,
    parameter int unsigned STEP       = DEF_STEP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr
);

    if (STEP == 0) begin : gBadStep
        $fatal(1, "ram_dump_ctrl: STEP must be non-zero");
    end else if (END_ADDR < START_ADDR) begin : gBadOrder
        $fatal(1, "ram_dump_ctrl: END_ADDR below START_ADDR");
    end else if (((END_ADDR - START_ADDR) % STEP) != 0) begin : gBadAlign
        $fatal(1, "ram_dump_ctrl: window is not a whole number of steps");
    end

    dumpState_e               state;
    logic [ADDR_W-1:0]        curAddr;
    logic                     rdVld_p1;
    logic [ADDR_W-1:0]        rdAddr_p1;
    logic                     fifoPush;
    logic                     fifoPop;
    logic                     fifoFull;
    logic                     fifoEmpty;
    logic [1:0]               fifoCount;
    logic [ADDR_W+DATA_W-1:0] fifoHead;
    logic [2:0]               occupancy;

    // Slots claimed after this cycle's pop, plus the read whose data is on ram_q.
    // Counting the pop lets a new read issue every cycle while the stream flows.
    assign occupancy = 3'(fifoCount) + 3'(rdVld_p1) - 3'(fifoPop);
    assign ram_rd_en = (state == SCAN) && (occupancy < 3'd2);
    assign ram_addr  = curAddr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            curAddr  <= '0;
            rdVld_p1 <= 1'b0;
        end else begin
            rdVld_p1 <= ram_rd_en;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !done) begin
                        state   <= SCAN;
                        busy    <= 1'b1;
                        curAddr <= ADDR_W'(START_ADDR);
                    end
                end
                SCAN: begin
                    if (ram_rd_en) begin
                        if (curAddr == ADDR_W'(END_ADDR)) state <= DRAIN;
                        else curAddr <= curAddr + ADDR_W'(STEP);
                    end
                end
                DRAIN: begin
                    if (fifoPop && (fifoCount == 2'd1) && !rdVld_p1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // p1: address of the read in flight, paired with ram_q for the push
    always_ff @(posedge clk) begin
        if (ram_rd_en) rdAddr_p1 <= curAddr;
    end

    assign fifoPush = rdVld_p1;
    assign fifoPop  = out_valid & out_ready;

    dump_fifo #(
        .WIDTH (ADDR_W + DATA_W)
    ) uFifo (
        .clk    (clk),
        .reset  (reset),
        .push   (fifoPush),
        .pop    (fifoPop),
        .wrData ({rdAddr_p1, ram_q}),
        .rdData (fifoHead),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .count  (fifoCount)
    );

    assign out_valid = !fifoEmpty;
    assign out_data  = fifoEmpty ? '0 : fifoHead[DATA_W-1:0];
    assign out_addr  = fifoEmpty ? '0 : fifoHead[DATA_W +: ADDR_W];

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(fifoPush && fifoFull && !fifoPop))
                else $error("ram_dump_ctrl: output buffer overflow");
        end
    end

endmodule
